// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage buffers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          PC_W     = 64;
  localparam int          INST_W   = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the optional stage performance counters.
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  // Count events, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/pipe_stage_buf_chk.sv
// Simulation-only invariants for pipe_stage_buf.
module pipe_stage_buf_chk
  import pipe_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] occupancy
);

  a_occ_le_two: assert property (@(posedge clk) disable iff (!rst_n) occupancy <= 2'd2);

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a 2-entry skid buffer, registered in_ready and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                FLUSH_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_d;
  logic [DATA_W-1:0] r_main_q;
  logic [DATA_W-1:0] r_skid_q;
  logic [DATA_W-1:0] w_main_d;
  logic [DATA_W-1:0] w_skid_d;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // Next state and next payloads; main always holds BUBBLE_VAL when empty.
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main_q;
    w_skid_d  = r_skid_q;
    if (flush) begin
      if (w_in_xfer && (FLUSH_HOLD == 0)) begin
        w_state_d = ONE;
        w_main_d  = in_data;
      end else begin
        w_state_d = EMPTY;
        w_main_d  = BUBBLE_VAL;
      end
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_d = ONE;
            w_main_d  = in_data;
          end else begin
            w_state_d = EMPTY;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_d = in_data;
          end else if (w_in_xfer) begin
            w_state_d = FULL;
            w_skid_d  = in_data;
          end else if (w_out_xfer) begin
            w_state_d = EMPTY;
            w_main_d  = BUBBLE_VAL;
          end else begin
            w_state_d = ONE;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            w_state_d = ONE;
            w_main_d  = r_skid_q;
          end else begin
            w_state_d = FULL;
          end
        end
        default: begin
          w_state_d = EMPTY;
          w_main_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main_q    <= BUBBLE_VAL;
      r_skid_q    <= BUBBLE_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_main_q    <= w_main_d;
      r_skid_q    <= w_skid_d;
      r_in_ready  <= (w_state_d != FULL);
      r_out_valid <= (w_state_d != EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_q;
  assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.W(32)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (r_out_valid & ~out_ready),
    .o_count (stall_cnt)
  );

  pipe_perf_cnt #(.W(32)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (flush & (r_state != EMPTY)),
    .o_count (flush_cnt)
  );
`endif

  pipe_stage_buf_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised bench for pipe_stage_buf: two instances (FLUSH_HOLD 0 and 1) against a queue model.
module tb_pipe_stage_buf;

  typedef logic [95:0] beat_t;
  typedef beat_t beat_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  beat_t       in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  beat_t       out_data0, out_data1;
  logic [1:0]  occ0, occ1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall0, flushc0, stall1, flushc1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(96), .FLUSH_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_ready(out_ready), .occupancy(occ0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall0), .flush_cnt(flushc0)
`endif
  );

  pipe_stage_buf #(.DATA_W(96), .FLUSH_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .occupancy(occ1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall1), .flush_cnt(flushc1)
`endif
  );

  // Model: a FIFO of at most two beats. Pop first, then flush, then push.
  function automatic beat_q_t step(beat_q_t q, bit hold, bit v, beat_t d, bit ordy, bit fl);
    bit take;
    take = v && (q.size() < 2);
    if (ordy && (q.size() > 0)) void'(q.pop_front());
    if (fl) q.delete();
    if (take && !(fl && hold)) q.push_back(d);
    return q;
  endfunction

  beat_q_t q0, q1;
  bit      m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_live = 1'b1;
    end else if (m_live) begin
      q0 = step(q0, 1'b0, in_valid, in_data, out_ready, flush);
      q1 = step(q1, 1'b1, in_valid, in_data, out_ready, flush);
    end
  end

  function automatic beat_t front(beat_q_t q);
    return (q.size() > 0) ? q[0] : 96'h0;
  endfunction

  task automatic check(string name, beat_t act, beat_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("valid0", {95'h0, out_valid0}, {95'h0, q0.size() > 0});
      check("data0",  out_data0, front(q0));
      check("occ0",   {94'h0, occ0}, beat_t'(q0.size()));
      check("rdy0",   {95'h0, in_ready0}, {95'h0, q0.size() < 2});
      check("valid1", {95'h0, out_valid1}, {95'h0, q1.size() > 0});
      check("data1",  out_data1, front(q1));
      check("occ1",   {94'h0, occ1}, beat_t'(q1.size()));
      check("rdy1",   {95'h0, in_ready1}, {95'h0, q1.size() < 2});
    end
  end

  task automatic cyc(bit v, beat_t d, bit ordy, bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit0(string name, beat_t data, logic [1:0] occ, bit vld, bit rdy);
    check({name, "_data"}, out_data0, data);
    check({name, "_occ"},  {94'h0, occ0}, {94'h0, occ});
    check({name, "_vld"},  {95'h0, out_valid0}, {95'h0, vld});
    check({name, "_rdy"},  {95'h0, in_ready0}, {95'h0, rdy});
    check({name, "_model"}, front(q0), data);
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b0, 96'h0, 1'b0, 1'b1);
    cyc(1'b1, 96'h5, 1'b0, 1'b1);
    lit0("reset", 96'h0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Streaming with latency 1.
    cyc(1'b1, 96'h1, 1'b1, 1'b0); lit0("s1", 96'h1, 2'd1, 1'b1, 1'b1);
    cyc(1'b1, 96'h2, 1'b1, 1'b0); lit0("s2", 96'h2, 2'd1, 1'b1, 1'b1);
    cyc(1'b1, 96'h3, 1'b1, 1'b0); lit0("s3", 96'h3, 2'd1, 1'b1, 1'b1);
    cyc(1'b0, 96'h0, 1'b1, 1'b0); lit0("s_end", 96'h0, 2'd0, 1'b0, 1'b1);

    // Skid fill and ordered drain.
    cyc(1'b1, 96'hA, 1'b0, 1'b0); lit0("k1", 96'hA, 2'd1, 1'b1, 1'b1);
    cyc(1'b1, 96'hB, 1'b0, 1'b0); lit0("k2", 96'hA, 2'd2, 1'b1, 1'b0);
    cyc(1'b1, 96'hE, 1'b0, 1'b0); lit0("k3", 96'hA, 2'd2, 1'b1, 1'b0);
    cyc(1'b0, 96'h0, 1'b1, 1'b0); lit0("k4", 96'hB, 2'd1, 1'b1, 1'b1);
    cyc(1'b0, 96'h0, 1'b1, 1'b0); lit0("k5", 96'h0, 2'd0, 1'b0, 1'b1);

    // Flush from FULL.
    cyc(1'b1, 96'hA, 1'b0, 1'b0);
    cyc(1'b1, 96'hB, 1'b0, 1'b0);
    cyc(1'b0, 96'h0, 1'b0, 1'b1); lit0("fl_full", 96'h0, 2'd0, 1'b0, 1'b1);

    // Flush with concurrent intake: survives only with FLUSH_HOLD=0.
    cyc(1'b1, 96'h5, 1'b0, 1'b0);
    cyc(1'b1, 96'hC, 1'b0, 1'b1); lit0("fl_in", 96'hC, 2'd1, 1'b1, 1'b1);
    check("fl_hold_occ", {94'h0, occ1}, 96'h0);
    check("fl_hold_data", out_data1, 96'h0);

    // Reset overrides flush while FULL.
    cyc(1'b0, 96'h0, 1'b1, 1'b0);
    cyc(1'b1, 96'hA, 1'b0, 1'b0);
    cyc(1'b1, 96'hB, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 96'h9, 1'b0, 1'b1); lit0("rst_full", 96'h0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 96'h0, 1'b0, 1'b0); lit0("rst_rel", 96'h0, 2'd0, 1'b0, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
    cyc(1'b1, 96'h7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 96'h0, 1'b0, 1'b0);
    cyc(1'b0, 96'h0, 1'b1, 1'b1);
    check("stall_cnt", {64'h0, stall0}, 96'd5);
    check("flush_cnt", {64'h0, flushc0}, 96'd1);
`endif

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 7, {$urandom(), $urandom(), $urandom()},
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register that replaces the fixed IF/ID-style latch.
- Generic payload with a valid/ready handshake, flush, and a 2-entry skid buffer, so upstream ready is registered and stalls do not form a combinational ready chain.
- Used between every pipeline stage (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A flush discards all held entries and drives a configurable bubble payload.

Parameters:
- DATA_W, 96, payload width in bits (e.g. 64-bit PC + 32-bit instruction).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload driven on out_data whenever out_valid=0.
- FLUSH_HOLD, 0, if 1, flush also blocks intake in the same cycle; if 0, a beat accepted in the flush cycle survives.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream beat present.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  downstream beat present.
- out_data  out  DATA_W  downstream payload (BUBBLE_VAL when out_valid=0).
- out_ready  in  1  downstream accepts.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Handshake:
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - out_data and out_valid are stable while out_valid & !out_ready.
- Storage:
  - Main register (main_q, main_v) drives the outputs directly.
  - Skid register (skid_q, skid_v) holds one beat.
- FSM states:
  - EMPTY (occ 0): in_ready=1, out_valid=0.
  - ONE (occ 1): in_ready=1, out_valid=1.
  - FULL (occ 2): in_ready=0, out_valid=1.
- Transitions, no flush:
  - EMPTY + in -> ONE; the beat appears on out_data the next cycle (latency 1).
  - ONE + in + out -> ONE; main reloads from in_data.
  - ONE + in, no out -> FULL; beat goes to skid.
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE; skid moves to main. in_ready=0, so no intake.
  - FULL, no out -> FULL; hold.
- in_ready is registered: it is 1 in the cycle after any state other than FULL.
- Flush (priority over all transfers, below reset):
  - Next state is EMPTY and both valids clear.
  - Output data is forced to BUBBLE_VAL.
  - With FLUSH_HOLD=0 and in_valid & in_ready in the flush cycle: next state is ONE, holding that beat, because it is younger than the flush point.
  - With FLUSH_HOLD=1: the next state is EMPTY regardless of intake.
  - in_ready=1 in the cycle after a flush.
- Reset:
  - rst_n=0 sampled at a rising edge gives EMPTY, out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0. Reset overrides flush.
  - Reset mid-transfer drops both entries silently.
- Simultaneous out_ready & flush: the downstream transfer in that cycle completes. Flush clears only what remains.
- No width arithmetic except the 2-bit occupancy, which never exceeds 2. Assert this in simulation.

Optional Feature:
- PIPE_STAGE_PERF_EN defined:
  - Adds 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while occupancy!=0.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - State enum {EMPTY, ONE, FULL} as a 2-bit typedef.
  - Constant NOP_INST = 32'h00000013.
  - Payload widths PC_W=64 and INST_W=32 for stage instances.
- Sub-module pipe_perf_cnt (saturating counter, width parameter), instantiated twice under the macro.
- The FSM and datapath stay in pipe_stage_buf.

Test Plan:
- Reset, then stream in_data=0x1,0x2,0x3 with out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle later; occupancy stays at 1; in_ready=1 throughout.
- Accept 0xA, drop out_ready, offer 0xB -> occupancy=2, in_ready=0 next cycle, out_data held at 0xA; raise out_ready -> 0xA then 0xB delivered in order, no loss or duplication.
- FULL (0xA,0xB) and assert flush, in_valid=0 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1.
- Occupancy 1 with flush=1 and in_valid=1, in_data=0xC:
  - FLUSH_HOLD=0 -> out_data=0xC, occupancy=1.
  - FLUSH_HOLD=1 -> occupancy=0.
- Hold rst_n=0 during FULL with flush=1 -> all outputs at reset values; releasing rst_n gives in_ready=1 with no stale beat.
- With PIPE_STAGE_PERF_EN, hold out_valid=1 & out_ready=0 for 5 cycles, then flush once -> stall_cnt=5, flush_cnt=1.
